// File: rtl/conv_output_collector.sv
// Collects valid-window convolution results, tags them with output-map (row,col) and buffers them in a FIFO.
// Latency: pixel accepted in cycle t reaches out_valid in cycle t+2 when the FIFO is empty.
// Backpressure: out_valid/out_ready handshake; a capture into a full FIFO without a pop is dropped and sets overflow. Build macro CONV_RELU_EN clamps negatives to 0.
module conv_output_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end
endmodule

module conv_output_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  pixel_valid,
    input  logic [DATA_WIDTH-1:0] conv_result,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  stream_error
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [7:0]            row;
        logic [7:0]            col;
    } entry_t;

    localparam logic [7:0] LAST = 8'(IMAGE_SIZE - 1);
    localparam logic [7:0] KM1  = 8'(KERNEL_SIZE - 1);

    state_t                state;
    logic [7:0]            r;
    logic [7:0]            c;
    logic [7:0]            r_nxt;
    logic [7:0]            c_nxt;
    logic [7:0]            r_q;
    logic [7:0]            c_q;
    logic                  pv_q;
    logic                  accept;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] sample;
    entry_t                push_entry;
    entry_t                head;

    assign accept = pixel_valid && (state != DRAIN);

    always_comb begin
        c_nxt = c + 8'd1;
        r_nxt = r;
        if (c == LAST) begin
            c_nxt = 8'd0;
            r_nxt = (r == LAST) ? 8'd0 : r + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            r            <= 8'd0;
            c            <= 8'd0;
            r_q          <= 8'd0;
            c_q          <= 8'd0;
            pv_q         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            stream_error <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            r            <= 8'd0;
            c            <= 8'd0;
            r_q          <= 8'd0;
            c_q          <= 8'd0;
            pv_q         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            stream_error <= 1'b0;
        end else begin
            pv_q       <= accept;
            frame_done <= 1'b0;
            if (accept) begin
                r_q <= r;
                c_q <= c;
            end
            if (capture && fifo_full && !pop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (pixel_valid) begin
                        r     <= r_nxt;
                        c     <= c_nxt;
                        busy  <= 1'b1;
                        state <= (r_nxt >= KM1) ? STREAM : FILL;
                    end
                end
                FILL, STREAM: begin
                    // A gap mid-frame aborts it; the pixel already in flight still lands.
                    if (!pixel_valid) begin
                        state        <= IDLE;
                        r            <= 8'd0;
                        c            <= 8'd0;
                        busy         <= 1'b0;
                        stream_error <= 1'b1;
                    end else begin
                        r <= r_nxt;
                        c <= c_nxt;
                        if (state == STREAM && r == LAST && c == LAST) begin
                            state      <= DRAIN;
                            frame_done <= 1'b1;
                        end else if (state == FILL && r_nxt >= KM1) begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_RELU_EN
    assign sample = conv_result[DATA_WIDTH-1] ? '0 : conv_result;
`else
    assign sample = conv_result;
`endif

    assign capture = pv_q && (r_q >= KM1) && (c_q >= KM1);
    assign push    = capture && !clear;
    assign pop     = out_valid && out_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.data = sample;
        push_entry.row  = r_q - KM1;
        push_entry.col  = c_q - KM1;
    end

    conv_output_fifo #(
        .WIDTH(DATA_WIDTH + 16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Head is masked so the outputs read as zero whenever nothing is buffered.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head.data : '0;
    assign out_row   = out_valid ? head.row  : 8'd0;
    assign out_col   = out_valid ? head.col  : 8'd0;
endmodule

// File: tb/tb_conv_output_collector.sv
// Scoreboard bench for conv_output_collector: directed frames push expected entries, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_conv_output_collector;
    localparam int DW   = 16;
    localparam int K    = 5;
    localparam int IMG  = 28;
    localparam int NWIN = (IMG - K + 1) * (IMG - K + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [DW-1:0] conv_result = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_row;
    logic [7:0]    out_col;
    logic          frame_done;
    logic          busy;
    logic          overflow;
    logic          stream_error;

    conv_output_collector #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .pixel_valid(pixel_valid),
        .conv_result(conv_result), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done), .busy(busy), .overflow(overflow),
        .stream_error(stream_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    r;
        logic [7:0]    c;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             n_vec = 0;
    int             n_bad = 0;
    int             cyc = 0;
    int             n_pop = 0;
    int             base = 0;
    int             done_cnt = 0;
    int             first_valid_cyc = -1;
    int             pix116_cyc = 0;
    bit             first_seen = 0;
    logic [DW+15:0] first_ent = '0;
    logic [DW+15:0] last_ent = '0;
    bit             cap_en = 0;
    int             cap_limit = 0;
    int             cap_taken = 0;
    bit             hold_pend = 0;
    logic [DW+15:0] hold_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix_val(input int fid, input int idx);
        if (fid == 3 && idx == 116) return 16'hFF00;
        return 16'(fid * 4099 + idx * 77 - 20000);
    endfunction

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef CONV_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pend && out_valid) check("hold_stable", {out_data, out_row, out_col}, hold_val);
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_data, out_row, out_col};
            if (out_valid && out_ready) begin
                n_pop++;
                if (!first_seen) begin
                    first_seen = 1;
                    first_ent  = {out_data, out_row, out_col};
                end
                last_ent = {out_data, out_row, out_col};
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h, expected no output", {out_data, out_row, out_col});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_entry", {out_data, out_row, out_col}, {mon_e.d, mon_e.r, mon_e.c});
                end
            end
        end
    end

    task automatic sb_push(input int idx, input logic [DW-1:0] v);
        exp_t e;
        int   r = idx / IMG;
        int   c = idx % IMG;
        if (cap_en && r >= K - 1 && c >= K - 1) begin
            if (cap_taken < cap_limit) begin
                e.d = relu(v);
                e.r = 8'(r - (K - 1));
                e.c = 8'(c - (K - 1));
                exp_q.push_back(e);
            end
            cap_taken++;
        end
    endtask

    // Drives npix contiguous pixels; conv_result for pixel i-1 rides alongside pixel i.
    task automatic drive_frame(input int npix, input int fid, input int ready_at, input bit end_gap);
        int last = end_gap ? npix : npix - 1;
        first_valid_cyc = -1;
        for (int i = 0; i <= last; i++) begin
            pixel_valid = (i < npix);
            if (i > 0) begin
                conv_result = pix_val(fid, i - 1);
                sb_push(i - 1, conv_result);
            end
            if (i == ready_at) out_ready = 1'b1;
            if (i == 116) pix116_cyc = cyc;
            if (!out_ready && i == 125) check("ovf_before_9th", overflow, 0);
            if (!out_ready && i == 126) check("ovf_at_9th", overflow, 1);
            if (i == 200) check("busy_mid_frame", busy, 1);
            @(posedge clk);
            #1;
        end
        if (end_gap) pixel_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, exp_q.size() + (out_valid ? 1 : 0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        #2 check("reset_outputs", {out_valid, out_data, out_row, out_col, frame_done, busy, overflow, stream_error}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Contiguous frame, always ready
        out_ready = 1'b1; cap_en = 1; cap_limit = 1 << 30; cap_taken = 0;
        base = n_pop; done_cnt = 0; first_seen = 0;
        drive_frame(IMG * IMG, 1, 0, 1);
        wait_drain("a_drain", 100);
        check("a_outputs", n_pop - base, NWIN);
        check("a_frame_done", done_cnt, 1);
        check("a_latency", first_valid_cyc - pix116_cyc, 2);
        check("a_first_tag", first_ent[15:0], 16'h0000);
        check("a_last_tag", last_ent[15:0], 16'h1717);
        check("a_flags", {overflow, stream_error, busy}, 0);

        // Never ready: only the first eight captures survive
        out_ready = 1'b0; cap_taken = 0; cap_limit = 8; base = n_pop; done_cnt = 0;
        drive_frame(IMG * IMG, 2, -1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("b_overflow", overflow, 1);
        check("b_held", out_valid, 1);
        check("b_frame_done", done_cnt, 1);
        check("b_no_pop", n_pop - base, 0);
        out_ready = 1'b1;
        wait_drain("b_drain", 50);
        check("b_drained", n_pop - base, 8);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("b_clear_flags", {overflow, out_valid, busy}, 0);

        // Full FIFO with pop and push in the same cycle
        out_ready = 1'b0; cap_limit = 1 << 30; cap_taken = 0; base = n_pop; done_cnt = 0;
        drive_frame(IMG * IMG, 4, 125, 1);
        wait_drain("c_drain", 100);
        check("c_outputs", n_pop - base, NWIN);
        check("c_no_overflow", overflow, 0);

        // Gap at pixel index 300
        cap_taken = 0; base = n_pop; done_cnt = 0;
        drive_frame(300, 5, 0, 1);
        check("d_stream_error", stream_error, 1);
        check("d_busy", busy, 0);
        wait_drain("d_drain", 50);
        check("d_outputs", n_pop - base, 160);
        check("d_no_done", done_cnt, 0);

        // New frame after the abort, negative value at the first window
        cap_taken = 0; base = n_pop; done_cnt = 0; first_seen = 0;
        drive_frame(IMG * IMG, 3, 0, 1);
        wait_drain("e_drain", 100);
        check("e_outputs", n_pop - base, NWIN);
        check("e_first_tag", first_ent[15:0], 16'h0000);
        check("e_relu_data", first_ent[31:16], relu(16'hFF00));
        check("e_frame_done", done_cnt, 1);

        // Async reset mid-stream, then clear mid-frame
        out_ready = 1'b0; cap_en = 0;
        drive_frame(205, 7, -1, 0);
        check("f_pre_reset", {busy, out_valid}, 2'b11);
        #2 reset = 1'b0;
        pixel_valid = 1'b0;
        #1 check("f_async_reset", {out_valid, out_data, out_row, out_col, frame_done, busy, overflow, stream_error}, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        drive_frame(205, 8, -1, 0);
        check("f_pre_clear", {busy, out_valid, overflow}, 3'b111);
        clear = 1'b1;
        conv_result = pix_val(8, 204);
        @(posedge clk);
        #1 clear = 1'b0;
        pixel_valid = 1'b0;
        check("f_clear_state", {out_valid, out_data, out_row, out_col, frame_done, busy, overflow, stream_error}, 0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        check("f_idle_after_clear", {stream_error, busy, out_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_output_collector.md
CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 16, fixed-point word width.
- KERNEL_SIZE, 5, convolution kernel edge.
- IMAGE_SIZE, 28, input image edge.
- FIFO_DEPTH, 8, output buffer entries (power of 2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous frame abort and flag clear.
- pixel_valid, input, 1, a pixel entered the convolver datapath this cycle.
- conv_result, input, DATA_WIDTH, signed datapath sum, valid the cycle after pixel_valid.
- out_ready, input, 1, downstream accepts out_data.
- out_valid, output, 1, out_data/out_row/out_col valid.
- out_data, output, DATA_WIDTH, signed convolution output.
- out_row, output, 8, output-map row.
- out_col, output, 8, output-map column.
- frame_done, output, 1, one-cycle pulse when the last window is captured.
- busy, output, 1, frame in progress.
- overflow, output, 1, sticky: a window was dropped because the FIFO was full.
- stream_error, output, 1, sticky: pixel_valid gap mid-frame.

Function
REQ-003 Pixel counters SHALL be row r and col c, 0..IMAGE_SIZE-1; each pixel_valid=1 cycle SHALL advance c, wrap c to 0 at IMAGE_SIZE-1 and increment r.
REQ-004 pixel_valid, r and c SHALL be registered one cycle; conv_result SHALL be sampled in the cycle after pixel acceptance.
REQ-005 A sample SHALL be captured only when the registered r>=KERNEL_SIZE-1 and c>=KERNEL_SIZE-1, tagged out_row=r-(KERNEL_SIZE-1), out_col=c-(KERNEL_SIZE-1); all other samples SHALL be discarded.
REQ-006 A frame SHALL yield exactly (IMAGE_SIZE-KERNEL_SIZE+1)^2 captures, 576 at defaults, in raster order.
REQ-007 FSM states SHALL be IDLE, FILL (valid rows not yet reached), STREAM, and DRAIN (last pixel accepted, final sample pending).
- IDLE->FILL on pixel_valid.
- FILL->STREAM when r reaches KERNEL_SIZE-1.
- STREAM->DRAIN on acceptance of pixel (IMAGE_SIZE-1, IMAGE_SIZE-1).
- DRAIN->IDLE the next cycle.
REQ-008 busy SHALL be 1 in FILL, STREAM and DRAIN; frame_done SHALL pulse for one cycle in DRAIN, coincident with the final capture.
REQ-009 pixel_valid=0 in FILL or STREAM SHALL set stream_error, reset r and c to 0, and return to IDLE; the next pixel_valid SHALL start a new frame.
REQ-010 Captures SHALL push {data,row,col} into a FIFO of FIFO_DEPTH entries; out_valid SHALL equal FIFO non-empty, and the outputs SHALL present the head entry.
REQ-011 Pop SHALL occur on out_valid&&out_ready; head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 Latency SHALL be: pixel accepted in cycle t, FIFO empty -> out_valid=1 in cycle t+2.
REQ-013 Push when full without pop SHALL drop the entry and set overflow; push and pop in the same cycle when full SHALL accept both, with count unchanged.
REQ-014 clear SHALL empty the FIFO, zero the counters, enter IDLE and clear the sticky flags on the next edge; clear SHALL override a simultaneous push.

Reset
REQ-015 reset=0 SHALL immediately force IDLE, empty the FIFO, zero the counters, and drive every output to 0, regardless of clk.

Configuration
REQ-016 Macro CONV_RELU_EN, when defined, SHALL clamp negative conv_result to 0 before FIFO push; when undefined, conv_result SHALL be stored unmodified.

Verification
REQ-017 Contiguous 784-pixel frame, out_ready=1 -> 576 outputs; first (0,0) equals conv_result the cycle after pixel index 116; last (23,23); one frame_done.
REQ-018 out_ready=0 for a full frame -> 8 entries held in order, overflow=1 at the 9th capture; out_ready=1 then drains exactly those 8 entries.
REQ-019 conv_result=16'hFF00 at a valid window -> out_data=0 with CONV_RELU_EN, 16'hFF00 without.
REQ-020 pixel_valid dropped at pixel index 300 -> stream_error=1, busy=0, no further captures; a new frame then produces out_row=0, out_col=0 first.
REQ-021 FIFO full with out_ready=1 during a capture -> no overflow, count remains 8.
REQ-022 reset=0 asserted mid-STREAM between edges -> all outputs 0 before the next edge; clear mid-frame -> identical state one edge later.
